// File: rtl/decode_stage.sv
// decode_stage: RV32I/RV64I decoder with registered handshake, EBREAK halt and saturating illegal counter
module decode_stage #(
  parameter int XLEN = 64,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [3:0]       out_alu_op,
  output logic             out_need_imm,
  output logic             out_is_lui,
  output logic             out_is_auipc,
  output logic             out_is_jal,
  output logic             out_is_jalr,
  output logic             out_is_branch,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_ebreak,
  output logic             out_illegal,
  input  logic             flush,
  input  logic             resume,
  output logic             halted,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam bit IS64 = (XLEN == 64);
  typedef enum logic {RUN, HALTED} state_t;
  state_t state, state_nx;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [3:0] op_base;
  logic accept, ok, sh_ok;
  logic [4:0] d_rd, d_rs1, d_rs2;
  logic [XLEN-1:0] d_imm;
  logic [3:0] d_alu;
  logic d_need, d_lui, d_auipc, d_jal, d_jalr, d_br, d_ld, d_st, d_eb;
  assign opc = in_inst[6:0];
  assign f3 = in_inst[14:12];
  assign f7 = in_inst[31:25];
  assign imm_i = XLEN'($signed(in_inst[31:20]));
  assign imm_s = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
  assign imm_b = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_inst[31:12], 12'b0}));
  assign imm_j = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
  assign accept = in_valid & in_ready;
  // funct3 to ALU op for OP/OP-IMM; SUB and SRA are the next code after ADD and SRL
  always_comb op_base = f3 == 3'd0 ? 4'd0 : f3 == 3'd1 ? 4'd2 : f3 == 3'd2 ? 4'd3 : f3 == 3'd3 ? 4'd4 :
                        f3 == 3'd4 ? 4'd5 : f3 == 3'd5 ? 4'd6 : f3 == 3'd6 ? 4'd8 : 4'd9;
  // Immediate shift encodings: funct6 must be SLL/SRL or SRA form; RV32 forbids shamt[5]
  always_comb sh_ok = (in_inst[31:26] == 6'b0 || (f3 == 3'd5 && in_inst[31:26] == 6'b010000)) && (IS64 || !in_inst[25]);
  // Combinational decode; anything not recognised collapses to a bare illegal bundle
  always_comb begin
    ok = 1'b0;
    d_rd = '0;
    d_rs1 = '0;
    d_rs2 = '0;
    d_imm = '0;
    d_alu = 4'd0;
    {d_need, d_lui, d_auipc, d_jal, d_jalr, d_br, d_ld, d_st, d_eb} = '0;
    case (opc)
      7'b0110111: begin ok = 1'b1; d_lui = 1'b1; d_need = 1'b1; d_rd = in_inst[11:7]; d_imm = imm_u; end
      7'b0010111: begin ok = 1'b1; d_auipc = 1'b1; d_need = 1'b1; d_rd = in_inst[11:7]; d_imm = imm_u; end
      7'b1101111: begin ok = 1'b1; d_jal = 1'b1; d_rd = in_inst[11:7]; d_imm = imm_j; end
      7'b1100111: begin
        ok = f3 == 3'd0; d_jalr = 1'b1; d_need = 1'b1;
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_imm = imm_i;
      end
      7'b1100011: begin
        ok = f3 != 3'd2 && f3 != 3'd3; d_br = 1'b1;
        d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20]; d_imm = imm_b;
      end
      7'b0000011: begin
        ok = IS64 ? f3 != 3'd7 : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7); d_ld = 1'b1; d_need = 1'b1;
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_imm = imm_i;
      end
      7'b0100011: begin
        ok = IS64 ? f3 <= 3'd3 : f3 <= 3'd2; d_st = 1'b1; d_need = 1'b1;
        d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20]; d_imm = imm_s;
      end
      7'b0010011: begin
        ok = (f3 == 3'd1 || f3 == 3'd5) ? sh_ok : 1'b1; d_need = 1'b1;
        d_alu = op_base + {3'b0, f3 == 3'd5 && in_inst[30]};
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_imm = imm_i;
      end
      7'b0110011: begin
        ok = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        d_alu = op_base + {3'b0, f7 == 7'h20};
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20];
      end
      7'b0011011: begin
        ok = IS64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'h00) || (f3 == 3'd5 && (f7 == 7'h00 || f7 == 7'h20)));
        d_need = 1'b1; d_alu = op_base + {3'b0, f3 == 3'd5 && in_inst[30]};
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_imm = imm_i;
      end
      7'b0111011: begin
        ok = IS64 && ((f7 == 7'h00 && (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        d_alu = op_base + {3'b0, f7 == 7'h20};
        d_rd = in_inst[11:7]; d_rs1 = in_inst[19:15]; d_rs2 = in_inst[24:20];
      end
      7'b1110011: begin ok = in_inst == 32'h0010_0073; d_eb = 1'b1; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d_rd = '0;
      d_rs1 = '0;
      d_rs2 = '0;
      d_imm = '0;
      d_alu = 4'd0;
      {d_need, d_lui, d_auipc, d_jal, d_jalr, d_br, d_ld, d_st, d_eb} = '0;
    end
  end
  // State register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= state_nx;
  // Next state: accepted EBREAK halts, resume releases; flush freezes the state
  always_comb state_nx = flush ? state : state == RUN ? (accept && d_eb ? HALTED : RUN) : (resume ? RUN : HALTED);
  // Outputs of the state machine: halt indication and upstream ready
  always_comb begin
    halted = state == HALTED;
    in_ready = !halted && (!out_valid || out_ready) && !flush;
  end
  // Output bundle: load on acceptance, drop on flush or consumption, hold otherwise
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc <= '0;
      out_rd <= '0;
      out_rs1 <= '0;
      out_rs2 <= '0;
      out_imm <= '0;
      out_alu_op <= '0;
      {out_need_imm, out_is_lui, out_is_auipc, out_is_jal, out_is_jalr} <= '0;
      {out_is_branch, out_is_load, out_is_store, out_is_ebreak, out_illegal} <= '0;
    end else if (flush) out_valid <= 1'b0;
    else if (accept) begin
      out_valid <= 1'b1;
      out_pc <= in_pc;
      out_rd <= d_rd;
      out_rs1 <= d_rs1;
      out_rs2 <= d_rs2;
      out_imm <= d_imm;
      out_alu_op <= d_alu;
      {out_need_imm, out_is_lui, out_is_auipc, out_is_jal, out_is_jalr} <= {d_need, d_lui, d_auipc, d_jal, d_jalr};
      {out_is_branch, out_is_load, out_is_store, out_is_ebreak, out_illegal} <= {d_br, d_ld, d_st, d_eb, !ok};
    end else if (out_ready) out_valid <= 1'b0;
  // Saturating count of accepted illegal instructions
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) illegal_cnt <= '0;
    else if (accept && !ok && !(&illegal_cnt)) illegal_cnt <= illegal_cnt + CNT_W'(1);
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a mask/match instruction-table model
module tb_decode_stage;
  localparam logic [3:0] C_LUI = 0, C_AUIPC = 1, C_JAL = 2, C_JALR = 3, C_BR = 4, C_LD = 5, C_ST = 6, C_OPI = 7, C_OP = 8, C_EB = 9;
  localparam logic [31:0] M3 = 32'h0000_707F, M7 = 32'hFE00_707F, MSH = 32'hFC00_707F;
  typedef struct packed {
    logic [63:0] pc;
    logic [4:0] rd, rs1, rs2;
    logic [63:0] imm;
    logic [3:0] alu;
    logic need, lui, auipc, jal, jalr, br, ld, st, eb, ill;
  } bun_t;
  typedef struct packed {
    logic [31:0] mask, match;
    logic [3:0] cls, alu;
  } ent_t;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0, flush = 0, resume = 0;
  logic [31:0] in_inst = 0;
  logic [63:0] in_pc = 0;
  logic in_ready, out_valid, halted;
  logic [63:0] out_pc, out_imm;
  logic [4:0] out_rd, out_rs1, out_rs2;
  logic [3:0] out_alu_op;
  logic out_need_imm, out_is_lui, out_is_auipc, out_is_jal, out_is_jalr;
  logic out_is_branch, out_is_load, out_is_store, out_is_ebreak, out_illegal;
  logic [7:0] illegal_cnt;
  bun_t dut_b, m_b, e;
  logic m_valid, m_halt;
  int m_cnt, tests = 0, fails = 0;
  ent_t tbl[$];
  int alu_of[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  decode_stage #(.XLEN(64), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_alu_op(out_alu_op), .out_need_imm(out_need_imm),
    .out_is_lui(out_is_lui), .out_is_auipc(out_is_auipc), .out_is_jal(out_is_jal), .out_is_jalr(out_is_jalr),
    .out_is_branch(out_is_branch), .out_is_load(out_is_load), .out_is_store(out_is_store),
    .out_is_ebreak(out_is_ebreak), .out_illegal(out_illegal), .flush(flush), .resume(resume),
    .halted(halted), .illegal_cnt(illegal_cnt)
  );
  assign dut_b = {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_need_imm, out_is_lui, out_is_auipc,
                  out_is_jal, out_is_jalr, out_is_branch, out_is_load, out_is_store, out_is_ebreak, out_illegal};
  always #5 clk = ~clk;
  task automatic add(input logic [31:0] mask, input logic [31:0] match, input logic [3:0] cls, input int alu);
    tbl.push_back('{mask, match, cls, 4'(alu)});
  endtask
  task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bun_t ref_dec(input logic [31:0] i, input logic [63:0] pc);
    bun_t b;
    int k;
    logic [3:0] c;
    longint s;
    b = '0;
    b.pc = pc;
    k = -1;
    s = longint'($signed(i));
    for (int j = 0; j < tbl.size(); j++) if (k < 0 && (i & tbl[j].mask) == tbl[j].match) k = j;
    if (k < 0) begin
      b.ill = 1'b1;
      return b;
    end
    c = tbl[k].cls;
    b.alu = tbl[k].alu;
    {b.lui, b.auipc, b.jal, b.jalr, b.br, b.ld, b.st, b.eb} = {c == C_LUI, c == C_AUIPC, c == C_JAL, c == C_JALR, c == C_BR, c == C_LD, c == C_ST, c == C_EB};
    b.need = c inside {C_OPI, C_LUI, C_AUIPC, C_JALR, C_LD, C_ST};
    if (c inside {C_LUI, C_AUIPC, C_JAL, C_JALR, C_LD, C_OPI, C_OP}) b.rd = i[11:7];
    if (c inside {C_JALR, C_BR, C_LD, C_ST, C_OPI, C_OP}) b.rs1 = i[19:15];
    if (c inside {C_BR, C_ST, C_OP}) b.rs2 = i[24:20];
    case (c)
      C_LUI, C_AUIPC: b.imm = (s >>> 12) <<< 12;
      C_JAL: b.imm = ((s >>> 31) <<< 20) | (longint'(i[19:12]) << 12) | (longint'(i[20]) << 11) | (longint'(i[30:21]) << 1);
      C_JALR, C_LD, C_OPI: b.imm = s >>> 20;
      C_ST: b.imm = ((s >>> 25) <<< 5) | longint'(i[11:7]);
      C_BR: b.imm = ((s >>> 31) <<< 12) | (longint'(i[7]) << 11) | (longint'(i[30:25]) << 5) | (longint'(i[11:8]) << 1);
      default: b.imm = 0;
    endcase
    return b;
  endfunction
  task automatic step(input logic iv, input logic [31:0] inst, input logic [63:0] pc, input logic ordy, input logic fl, input logic rs);
    logic exp_rdy, acc, old_halt;
    in_valid = iv;
    in_inst = inst;
    in_pc = pc;
    out_ready = ordy;
    flush = fl;
    resume = rs;
    #1;
    exp_rdy = !m_halt && (!m_valid || ordy) && !fl;
    chk("in_ready", in_ready, exp_rdy);
    acc = iv && exp_rdy;
    old_halt = m_halt;
    if (fl) m_valid = 0;
    else if (acc) begin
      m_valid = 1;
      m_b = ref_dec(inst, pc);
      if (m_b.ill && m_cnt < 255) m_cnt++;
      if (m_b.eb) m_halt = 1;
    end else if (ordy) m_valid = 0;
    if (!fl && old_halt && rs) m_halt = 0;
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    chk("halted", halted, m_halt);
    chk("illegal_cnt", illegal_cnt, m_cnt);
    if (m_valid) chk("bundle", dut_b, m_b);
  endtask
  task automatic do_reset();
    in_valid = 0;
    flush = 0;
    resume = 0;
    rst_n = 0;
    #1;
    m_valid = 0;
    m_halt = 0;
    m_cnt = 0;
    m_b = '0;
    chk("rst_valid", out_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_bundle", dut_b, 0);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask
  initial begin
    add(32'h7F, 32'h37, C_LUI, 0);
    add(32'h7F, 32'h17, C_AUIPC, 0);
    add(32'h7F, 32'h6F, C_JAL, 0);
    add(M3, 32'h67, C_JALR, 0);
    for (int f = 0; f < 8; f++) if (f != 2 && f != 3) add(M3, 32'h63 | (32'(f) << 12), C_BR, 0);
    for (int f = 0; f < 7; f++) add(M3, 32'h03 | (32'(f) << 12), C_LD, 0);
    for (int f = 0; f < 4; f++) add(M3, 32'h23 | (32'(f) << 12), C_ST, 0);
    for (int f = 0; f < 8; f++) if (f != 1 && f != 5) add(M3, 32'h13 | (32'(f) << 12), C_OPI, alu_of[f]);
    add(MSH, 32'h0000_1013, C_OPI, 2);
    add(MSH, 32'h0000_5013, C_OPI, 6);
    add(MSH, 32'h4000_5013, C_OPI, 7);
    for (int f = 0; f < 8; f++) add(M7, 32'h33 | (32'(f) << 12), C_OP, alu_of[f]);
    add(M7, 32'h4000_0033, C_OP, 1);
    add(M7, 32'h4000_5033, C_OP, 7);
    add(M3, 32'h0000_001B, C_OPI, 0);
    add(M7, 32'h0000_101B, C_OPI, 2);
    add(M7, 32'h0000_501B, C_OPI, 6);
    add(M7, 32'h4000_501B, C_OPI, 7);
    add(M7, 32'h0000_003B, C_OP, 0);
    add(M7, 32'h4000_003B, C_OP, 1);
    add(M7, 32'h0000_103B, C_OP, 2);
    add(M7, 32'h0000_503B, C_OP, 6);
    add(M7, 32'h4000_503B, C_OP, 7);
    add(32'hFFFF_FFFF, 32'h0010_0073, C_EB, 0);
    @(posedge clk);
    #1;
    do_reset();
    step(1, 32'h0050_0093, 64'h1000, 1, 0, 0);
    e = '0; e.pc = 64'h1000; e.rd = 1; e.imm = 5; e.need = 1;
    chk("addi", dut_b, e);
    step(1, 32'h1234_5117, 64'h1004, 1, 0, 0);
    e = '0; e.pc = 64'h1004; e.rd = 2; e.imm = 64'h0000_0000_1234_5000; e.auipc = 1; e.need = 1;
    chk("auipc", dut_b, e);
    step(1, 32'hFFDF_F0EF, 64'h1008, 1, 0, 0);
    e = '0; e.pc = 64'h1008; e.rd = 1; e.imm = 64'hFFFF_FFFF_FFFF_FFFC; e.jal = 1;
    chk("jal", dut_b, e);
    step(1, 32'h0020_8133, 64'h2000, 1, 0, 0);
    for (int n = 0; n < 3; n++) begin
      step(1, 32'h4020_81B3, 64'h2004, 0, 0, 0);
      chk("bp_ready", in_ready, 0);
      chk("bp_hold_pc", out_pc, 64'h2000);
    end
    step(1, 32'h4020_81B3, 64'h2004, 1, 0, 0);
    chk("bp_next_pc", out_pc, 64'h2004);
    chk("bp_next_alu", out_alu_op, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("bp_drained", out_valid, 0);
    step(1, 32'h0010_0073, 64'h3000, 1, 0, 0);
    chk("ebreak_halted", halted, 1);
    chk("ebreak_flag", out_is_ebreak, 1);
    for (int n = 0; n < 5; n++) begin
      step(1, 32'h0050_0093, 64'h3004, 1, 0, 0);
      chk("halt_ready", in_ready, 0);
    end
    step(0, 0, 0, 1, 0, 1);
    chk("resume_ready", in_ready, 1);
    step(1, 32'h0050_0093, 64'h3004, 1, 0, 0);
    chk("resume_accept_pc", out_pc, 64'h3004);
    for (int n = 0; n < 260; n++) begin
      step(1, 32'h0, 64'h4000 + 64'(4 * n), 1, 0, 0);
      chk("zero_illegal", out_illegal, 1);
    end
    chk("cnt_sat", illegal_cnt, 8'hFF);
    step(1, 32'h0050_0093, 64'h5000, 0, 0, 0);
    step(1, 32'h0, 64'h5004, 0, 1, 0);
    chk("flush_valid", out_valid, 0);
    chk("flush_cnt", illegal_cnt, 8'hFF);
    step(1, 32'h0050_0093, 64'h6000, 0, 0, 0);
    do_reset();
    step(1, 32'h0050_0093, 64'h7000, 1, 0, 0);
    chk("post_rst_accept", out_valid, 1);
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ri;
      ent_t re;
      re = tbl[$urandom_range(tbl.size() - 1)];
      ri = ($urandom_range(3) == 0) ? $urandom : (($urandom & ~re.mask) | re.match);
      step($urandom_range(3) != 0, ri, {$urandom, $urandom}, $urandom_range(3) != 0, $urandom_range(15) == 0, $urandom_range(7) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
